itcm_port_arbiter: RTL

// - Shares the ITCM (two 32-bit banks, even/odd word interleave, 64-bit row) between instruction fetch (IFU) and load/store unit (LSU).
// - One request granted per cycle; the bank chip-selects are driven from the grant; the read response is routed back to its owner one cycle later.
// - Sits in top between core and the ITCM SRAM banks; the LSU uses this path for data/signature accesses in the 0x80xx_xxxx region.

---
 rtl/tcm_pkg.sv | 12 +
 rtl/itcm_rsp_route.sv | 46 ++++
 rtl/itcm_port_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/tcm_pkg.sv
// Shared ITCM constants and the response-owner encoding used by the port arbiter.
package tcm_pkg;
  localparam int TCM_BYTES_DEF = 16384;
  localparam int TCM_BANKS     = 2;
  localparam int BANK_SEL_BIT  = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } tcm_owner_e;
endpackage

// File: rtl/itcm_rsp_route.sv
// Remembers who was granted last cycle and steers the bank read data back to that owner.
module itcm_rsp_route
  import tcm_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_cpurst,
  input  logic        i_ifu_gnt,
  input  logic        i_lsu_gnt,
  input  logic        i_lsu_bank,
  input  logic        i_lsu_wen,
  input  logic [63:0] i_tcm_rdata,
  output logic        o_ifu_rsp_valid,
  output logic [63:0] o_ifu_rsp_rdata,
  output logic        o_lsu_rsp_valid,
  output logic [31:0] o_lsu_rsp_rdata
);
  tcm_owner_e r_owner;
  logic       r_bank;
  logic       r_wr;
  logic       w_ifu_v;
  logic       w_lsu_v;

  always_ff @(posedge i_clk) begin
    if (i_cpurst) begin
      r_owner <= OWN_NONE;
      r_bank  <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_owner <= i_lsu_gnt ? OWN_LSU : (i_ifu_gnt ? OWN_IFU : OWN_NONE);
      if (i_lsu_gnt) begin
        r_bank <= i_lsu_bank;
        r_wr   <= i_lsu_wen;
      end
    end
  end

  // A reset arriving while a response is pending drops it immediately.
  assign w_ifu_v = (r_owner == OWN_IFU) && !i_cpurst;
  assign w_lsu_v = (r_owner == OWN_LSU) && !i_cpurst;

  assign o_ifu_rsp_valid = w_ifu_v;
  assign o_ifu_rsp_rdata = w_ifu_v ? i_tcm_rdata : 64'd0;
  assign o_lsu_rsp_valid = w_lsu_v;
  assign o_lsu_rsp_rdata = (w_lsu_v && !r_wr) ?
                           (r_bank ? i_tcm_rdata[63:32] : i_tcm_rdata[31:0]) : 32'd0;
endmodule

// File: rtl/itcm_port_arbiter.sv
// ITCM port arbiter: LSU-over-IFU grant onto two interleaved 32-bit banks.
// Define ITCM_ARB_AGE_EN to add the IFU anti-starvation age counter.
module itcm_port_arbiter
  import tcm_pkg::*;
#(
  parameter  int TCM_BYTES = TCM_BYTES_DEF,
  parameter  int MAX_WAIT  = 4,
  localparam int IDX_W     = $clog2(TCM_BYTES / 8)
) (
  input  logic                   i_clk,
  input  logic                   i_cpurst,
  input  logic                   i_ifu_req_valid,
  output logic                   o_ifu_req_ready,
  input  logic [31:0]            i_ifu_req_addr,
  output logic                   o_ifu_rsp_valid,
  output logic [63:0]            o_ifu_rsp_rdata,
  input  logic                   i_lsu_req_valid,
  output logic                   o_lsu_req_ready,
  input  logic [31:0]            i_lsu_req_addr,
  input  logic                   i_lsu_req_wen,
  input  logic [31:0]            i_lsu_req_wdata,
  input  logic [3:0]             i_lsu_req_wstrb,
  output logic                   o_lsu_rsp_valid,
  output logic [31:0]            o_lsu_rsp_rdata,
  output logic [TCM_BANKS-1:0]   o_tcm_cs,
  output logic [TCM_BANKS-1:0]   o_tcm_we,
  output logic [2*IDX_W-1:0]     o_tcm_addr,
  output logic [63:0]            o_tcm_wdata,
  output logic [7:0]             o_tcm_wstrb,
  input  logic [63:0]            i_tcm_rdata
);
  logic [IDX_W-1:0] w_ifu_row;
  logic [IDX_W-1:0] w_lsu_row;
  logic             w_lsu_bank;
  logic             w_age_win;
  logic             w_ifu_gnt;
  logic             w_lsu_gnt;
  logic             w_unused_addr;

  // Upper address bits are dropped so accesses wrap modulo the TCM size.
  assign w_ifu_row     = i_ifu_req_addr[IDX_W+2:3];
  assign w_lsu_row     = i_lsu_req_addr[IDX_W+2:3];
  assign w_lsu_bank    = i_lsu_req_addr[BANK_SEL_BIT];
  assign w_unused_addr = ^{i_ifu_req_addr[31:IDX_W+3], i_ifu_req_addr[2:0],
                           i_lsu_req_addr[31:IDX_W+3], i_lsu_req_addr[1:0]};

`ifdef ITCM_ARB_AGE_EN
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  logic [AGE_W-1:0] r_age;

  assign w_age_win = i_ifu_req_valid && (r_age == AGE_W'(MAX_WAIT));

  always_ff @(posedge i_clk) begin
    if (i_cpurst || !i_ifu_req_valid || w_ifu_gnt) begin
      r_age <= '0;
    end else if (r_age != AGE_W'(MAX_WAIT)) begin
      r_age <= r_age + 1'b1;
    end
  end
`else
  logic w_unused_max_wait;
  assign w_unused_max_wait = (MAX_WAIT != 0);
  assign w_age_win         = 1'b0;
`endif

  assign w_lsu_gnt = !i_cpurst && i_lsu_req_valid && !w_age_win;
  assign w_ifu_gnt = !i_cpurst && i_ifu_req_valid && (!i_lsu_req_valid || w_age_win);

  assign o_lsu_req_ready = w_lsu_gnt;
  assign o_ifu_req_ready = w_ifu_gnt;
  assign o_tcm_wdata     = {i_lsu_req_wdata, i_lsu_req_wdata};

  always_comb begin
    o_tcm_cs    = '0;
    o_tcm_we    = '0;
    o_tcm_wstrb = '0;
    o_tcm_addr  = {w_ifu_row, w_ifu_row};
    if (w_lsu_gnt) begin
      o_tcm_cs[w_lsu_bank] = 1'b1;
      o_tcm_we[w_lsu_bank] = i_lsu_req_wen;
      o_tcm_addr           = {w_lsu_row, w_lsu_row};
      if (i_lsu_req_wen) begin
        if (w_lsu_bank) o_tcm_wstrb[7:4] = i_lsu_req_wstrb;
        else            o_tcm_wstrb[3:0] = i_lsu_req_wstrb;
      end
    end else if (w_ifu_gnt) begin
      o_tcm_cs = 2'b11;
    end
  end

  itcm_rsp_route u_rsp_route (
    .i_clk           (i_clk),
    .i_cpurst        (i_cpurst),
    .i_ifu_gnt       (w_ifu_gnt),
    .i_lsu_gnt       (w_lsu_gnt),
    .i_lsu_bank      (w_lsu_bank),
    .i_lsu_wen       (i_lsu_req_wen),
    .i_tcm_rdata     (i_tcm_rdata),
    .o_ifu_rsp_valid (o_ifu_rsp_valid),
    .o_ifu_rsp_rdata (o_ifu_rsp_rdata),
    .o_lsu_rsp_valid (o_lsu_rsp_valid),
    .o_lsu_rsp_rdata (o_lsu_rsp_rdata)
  );
endmodule
